// File: rtl/apu_pulse_seq.sv
// Purpose: APU pulse-channel waveform stage (duty sequencer, envelope, length counter, output gate).
// Latency: register writes and strobes update state on the next clk edge; out/active follow one edge later.
// Backpressure: none; every strobe and write is consumed in the cycle it is presented.
//
// Ports:
//   clk, n_reset          APU clock, asynchronous active-low reset
//   wr, addr, data        channel register write (addr 0 = duty/envelope, addr 3 = length/restart)
//   en                    channel enable; low forces the length counter to zero
//   timer_tick            period-timer reload strobe, advances the duty step
//   qframe, hframe        quarter/half frame strobes, clock envelope and length counter
//   mute                  sweep-unit mute
//   out                   4-bit channel sample (registered)
//   active                length counter non-zero (registered)
module apu_pulse_seq (
    input  logic       clk,
    input  logic       n_reset,
    input  logic       wr,
    input  logic [1:0] addr,
    input  logic [7:0] data,
    input  logic       en,
    input  logic       timer_tick,
    input  logic       qframe,
    input  logic       hframe,
    input  logic       mute,
    output logic [3:0] out,
    output logic       active
);

    // Length table, indexed by data[7:3] of a register-3 write.
    function automatic logic [7:0] len_lut(input logic [4:0] idx);
        logic [7:0] v;
        case (idx)
            5'd0:  v = 8'd10;
            5'd1:  v = 8'd254;
            5'd2:  v = 8'd20;
            5'd3:  v = 8'd2;
            5'd4:  v = 8'd40;
            5'd5:  v = 8'd4;
            5'd6:  v = 8'd80;
            5'd7:  v = 8'd6;
            5'd8:  v = 8'd160;
            5'd9:  v = 8'd8;
            5'd10: v = 8'd60;
            5'd11: v = 8'd10;
            5'd12: v = 8'd14;
            5'd13: v = 8'd12;
            5'd14: v = 8'd26;
            5'd15: v = 8'd14;
            5'd16: v = 8'd12;
            5'd17: v = 8'd16;
            5'd18: v = 8'd24;
            5'd19: v = 8'd18;
            5'd20: v = 8'd48;
            5'd21: v = 8'd20;
            5'd22: v = 8'd96;
            5'd23: v = 8'd22;
            5'd24: v = 8'd192;
            5'd25: v = 8'd24;
            5'd26: v = 8'd72;
            5'd27: v = 8'd26;
            5'd28: v = 8'd16;
            5'd29: v = 8'd28;
            5'd30: v = 8'd32;
            default: v = 8'd30;
        endcase
        return v;
    endfunction

    // Duty patterns; bit n of the pattern is the waveform level at step n.
    function automatic logic seq_bit(input logic [1:0] duty, input logic [2:0] step);
        logic [7:0] pat;
        case (duty)
            2'd0:    pat = 8'b0000_0010;
            2'd1:    pat = 8'b0000_0110;
            2'd2:    pat = 8'b0001_1110;
            default: pat = 8'b1111_1001;
        endcase
        return pat[step];
    endfunction

    // Register file (reg 0)
    logic [1:0] duty_q,  duty_d;
    logic       halt_q,  halt_d;
    logic       cnst_q,  cnst_d;
    logic [3:0] vol_q,   vol_d;

    // Sequencer, envelope and length state
    logic [2:0] step_q,      step_d;
    logic       env_start_q, env_start_d;
    logic [3:0] decay_q,     decay_d;
    logic [3:0] div_q,       div_d;
    logic [7:0] len_q,       len_d;

    // Output stage
    logic       mute_q,   mute_d;
    logic [3:0] out_q,    out_d;
    logic       active_q, active_d;

    logic       wr_reg0;
    logic       wr_reg3;
    logic [3:0] volume;

    assign wr_reg0 = wr && (addr == 2'd0);
    assign wr_reg3 = wr && (addr == 2'd3);

    // Register 0 fields.
    always_comb begin
        duty_d = duty_q;
        halt_d = halt_q;
        cnst_d = cnst_q;
        vol_d  = vol_q;
        if (wr_reg0) begin
            duty_d = data[7:6];
            halt_d = data[5];
            cnst_d = data[4];
            vol_d  = data[3:0];
        end
    end

    // Duty step: a restart write overrides a coincident timer tick.
    always_comb begin
        step_d = step_q;
        if (wr_reg3) begin
            step_d = 3'd0;
        end else if (timer_tick) begin
            step_d = step_q + 3'd1;
        end
    end

    // Envelope. All decisions use the pre-write register values, so a reg 0
    // write in the same cycle as qframe reloads the divider from the old vol,
    // and a reg 3 write sets env_start only after this cycle's qframe used it.
    always_comb begin
        env_start_d = env_start_q;
        decay_d     = decay_q;
        div_d       = div_q;
        if (qframe) begin
            if (env_start_q) begin
                env_start_d = 1'b0;
                decay_d     = 4'd15;
                div_d       = vol_q;
            end else if (div_q == 4'd0) begin
                div_d = vol_q;
                if (decay_q != 4'd0) begin
                    decay_d = decay_q - 4'd1;
                end else if (halt_q) begin
                    decay_d = 4'd15;
                end
            end else begin
                div_d = div_q - 4'd1;
            end
        end
        if (wr_reg3) begin
            env_start_d = 1'b1;
        end
    end

    // Length counter. Priority, lowest to highest: hframe decrement, reload
    // from a reg 3 write, forced clear while the channel is disabled.
    always_comb begin
        len_d = len_q;
        if (hframe && (len_q != 8'd0) && !halt_q) begin
            len_d = len_q - 8'd1;
        end
        if (wr_reg3 && en) begin
            len_d = len_lut(data[7:3]);
        end
        if (!en) begin
            len_d = 8'd0;
        end
    end

    // Output stage. mute is staged like the other causes so that it, too,
    // reaches out two edges after it is presented.
    assign volume = cnst_q ? vol_q : decay_q;

    always_comb begin
        mute_d   = mute;
        active_d = (len_q != 8'd0);
        out_d    = 4'd0;
        if ((len_q != 8'd0) && seq_bit(duty_q, step_q) && !mute_q) begin
            out_d = volume;
        end
    end

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            duty_q      <= 2'd0;
            halt_q      <= 1'b0;
            cnst_q      <= 1'b0;
            vol_q       <= 4'd0;
            step_q      <= 3'd0;
            env_start_q <= 1'b0;
            decay_q     <= 4'd0;
            div_q       <= 4'd0;
            len_q       <= 8'd0;
            mute_q      <= 1'b0;
            out_q       <= 4'd0;
            active_q    <= 1'b0;
        end else begin
            duty_q      <= duty_d;
            halt_q      <= halt_d;
            cnst_q      <= cnst_d;
            vol_q       <= vol_d;
            step_q      <= step_d;
            env_start_q <= env_start_d;
            decay_q     <= decay_d;
            div_q       <= div_d;
            len_q       <= len_d;
            mute_q      <= mute_d;
            out_q       <= out_d;
            active_q    <= active_d;
        end
    end

    assign out    = out_q;
    assign active = active_q;

endmodule

// File: tb/tb_apu_pulse_seq.sv
// Purpose: directed scoreboard bench for apu_pulse_seq.
// Latency: expectations are pushed when stimulus is driven and popped once the registered output settles.
// Backpressure: not applicable; the bench drives strobes freely.
module tb_apu_pulse_seq;

    logic       clk;
    logic       n_reset;
    logic       wr;
    logic [1:0] addr;
    logic [7:0] data;
    logic       en;
    logic       timer_tick;
    logic       qframe;
    logic       hframe;
    logic       mute;
    logic [3:0] out;
    logic       active;

    int checks = 0;
    int errors = 0;

    typedef struct {
        string      tag;
        logic [3:0] val;
        bit         is_active;
    } exp_t;

    exp_t sb[$];

    logic [3:0] exp_duty2 [8] = '{4'd15, 4'd15, 4'd15, 4'd15, 4'd0, 4'd0, 4'd0, 4'd0};
    logic [3:0] exp_duty3 [8] = '{4'd0, 4'd0, 4'd15, 4'd15, 4'd15, 4'd15, 4'd15, 4'd15};

    apu_pulse_seq dut (
        .clk        (clk),
        .n_reset    (n_reset),
        .wr         (wr),
        .addr       (addr),
        .data       (data),
        .en         (en),
        .timer_tick (timer_tick),
        .qframe     (qframe),
        .hframe     (hframe),
        .mute       (mute),
        .out        (out),
        .active     (active)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_o(input string tag, input logic [3:0] v);
        exp_t e;
        e.tag = tag;
        e.val = v;
        e.is_active = 1'b0;
        sb.push_back(e);
    endtask

    task automatic expect_a(input string tag, input logic v);
        exp_t e;
        e.tag = tag;
        e.val = {3'b000, v};
        e.is_active = 1'b1;
        sb.push_back(e);
    endtask

    task automatic check_sb();
        exp_t e;
        logic [3:0] obs;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            obs = e.is_active ? {3'b000, active} : out;
            checks++;
            assert (obs === e.val) else begin
                errors++;
                $error("FAIL %s: observed %0d expected %0d", e.tag, obs, e.val);
            end
        end
    endtask

    task automatic wreg(input logic [1:0] a, input logic [7:0] d);
        wr = 1'b1;
        addr = a;
        data = d;
        cyc();
        wr = 1'b0;
    endtask

    task automatic pulse_tick();
        timer_tick = 1'b1;
        cyc();
        timer_tick = 1'b0;
    endtask

    task automatic pulse_qf();
        qframe = 1'b1;
        cyc();
        qframe = 1'b0;
    endtask

    task automatic pulse_hf();
        hframe = 1'b1;
        cyc();
        hframe = 1'b0;
    endtask

    initial begin
        int q;
        logic [3:0] ev;

        n_reset = 1'b0;
        wr = 1'b0;
        addr = 2'd0;
        data = 8'd0;
        en = 1'b0;
        timer_tick = 1'b0;
        qframe = 1'b0;
        hframe = 1'b0;
        mute = 1'b0;

        // Reset state
        #3;
        expect_o("rst_out", 4'd0);
        expect_a("rst_active", 1'b0);
        check_sb();
        repeat (2) @(posedge clk);
        #1;
        n_reset = 1'b1;
        cyc();
        expect_o("post_rst_out", 4'd0);
        expect_a("post_rst_active", 1'b0);
        check_sb();

        // Duty waveform, duty 2 then duty 3, constant volume 15
        en = 1'b1;
        cyc();
        wreg(2'd0, 8'hBF);
        wreg(2'd3, 8'h08);
        expect_a("duty2_active", 1'b1);
        expect_o("duty2_step0", 4'd0);
        cyc();
        check_sb();
        for (int i = 0; i < 8; i++) begin
            expect_o($sformatf("duty2_tick%0d", i + 1), exp_duty2[i]);
            pulse_tick();
            cyc();
            check_sb();
        end
        wreg(2'd0, 8'hFF);
        for (int i = 0; i < 8; i++) begin
            expect_o($sformatf("duty3_tick%0d", i + 1), exp_duty3[i]);
            pulse_tick();
            cyc();
            check_sb();
        end

        // Length countdown: LEN[3] = 2
        wreg(2'd0, 8'h1F);
        wreg(2'd3, 8'h18);
        expect_a("len2_loaded", 1'b1);
        cyc();
        check_sb();
        expect_a("len2_hf1", 1'b1);
        pulse_hf();
        cyc();
        check_sb();
        expect_a("len2_hf2_active", 1'b0);
        expect_o("len2_hf2_out", 4'd0);
        pulse_hf();
        cyc();
        check_sb();
        expect_a("len2_hf3_floor", 1'b0);
        pulse_hf();
        cyc();
        check_sb();
        wreg(2'd0, 8'h3F);
        wreg(2'd3, 8'h18);
        expect_a("len_halt_hold", 1'b1);
        repeat (3) pulse_hf();
        cyc();
        check_sb();

        // Envelope: vol 2, no loop; duty 0 parked at step 1 so out shows decay
        wreg(2'd0, 8'h02);
        wreg(2'd3, 8'h08);
        pulse_tick();
        expect_o("env_before_qf", 4'd0);
        cyc();
        check_sb();
        for (q = 1; q <= 48; q++) begin
            ev = ((q - 1) / 3 >= 15) ? 4'd0 : 4'(15 - (q - 1) / 3);
            expect_o($sformatf("env_q%0d", q), ev);
            pulse_qf();
            cyc();
            check_sb();
        end
        wreg(2'd0, 8'h22);
        expect_o("env_loop_q49", 4'd15);
        pulse_qf();
        cyc();
        check_sb();

        // Enable gating
        en = 1'b0;
        expect_a("en_drop", 1'b0);
        cyc();
        cyc();
        check_sb();
        wreg(2'd3, 8'h08);
        expect_a("en_off_reload", 1'b0);
        cyc();
        check_sb();
        en = 1'b1;
        cyc();

        // Reg 3 write + hframe: length must be a full 254
        wreg(2'd0, 8'h1F);
        wr = 1'b1;
        addr = 2'd3;
        data = 8'h08;
        hframe = 1'b1;
        cyc();
        wr = 1'b0;
        hframe = 1'b0;
        repeat (253) pulse_hf();
        expect_a("len254_after253", 1'b1);
        cyc();
        check_sb();
        expect_a("len254_after254", 1'b0);
        pulse_hf();
        cyc();
        check_sb();

        // Reg 3 write + timer_tick: restart wins (duty 2: step0 low, step4 high)
        wreg(2'd0, 8'h9F);
        wreg(2'd3, 8'h08);
        repeat (3) pulse_tick();
        expect_o("restart_pre_step3", 4'd15);
        cyc();
        check_sb();
        wr = 1'b1;
        addr = 2'd3;
        data = 8'h08;
        timer_tick = 1'b1;
        cyc();
        wr = 1'b0;
        timer_tick = 1'b0;
        expect_o("restart_step0", 4'd0);
        cyc();
        check_sb();
        expect_o("restart_then_step1", 4'd15);
        pulse_tick();
        cyc();
        check_sb();

        // Reg 0 write + qframe: divider reloads from the old vol (4, not 1)
        wreg(2'd0, 8'h04);
        wreg(2'd3, 8'h08);
        pulse_tick();
        expect_o("divold_start", 4'd15);
        pulse_qf();
        cyc();
        check_sb();
        repeat (4) pulse_qf();
        wr = 1'b1;
        addr = 2'd0;
        data = 8'h01;
        qframe = 1'b1;
        cyc();
        wr = 1'b0;
        qframe = 1'b0;
        expect_o("divold_dec14", 4'd14);
        cyc();
        check_sb();
        expect_o("divold_hold14", 4'd14);
        repeat (2) pulse_qf();
        cyc();
        check_sb();
        expect_o("divold_dec13", 4'd13);
        repeat (3) pulse_qf();
        cyc();
        check_sb();

        // Mute
        mute = 1'b1;
        expect_o("mute_out", 4'd0);
        expect_a("mute_active", 1'b1);
        cyc();
        cyc();
        check_sb();
        mute = 1'b0;
        expect_o("unmute_out", 4'd13);
        cyc();
        cyc();
        check_sb();

        // Asynchronous reset mid-waveform
        n_reset = 1'b0;
        #1;
        expect_o("arst_out", 4'd0);
        expect_a("arst_active", 1'b0);
        check_sb();
        cyc();
        n_reset = 1'b1;
        expect_o("arst_release_out", 4'd0);
        expect_a("arst_release_active", 1'b0);
        cyc();
        check_sb();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
